// File: rtl/afpm_mul_normalize.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : afpm_mul_normalize
// Purpose  : Two-stage normalize/round/pack stage after the approximate
//            significand multiplier; emits a packed float32 product.
// Options  : AFPM_ROUND_NEAREST_EN -> round to nearest even (else truncate)
// Revision : 1.0 - initial release
// ============================================================================
module afpm_mul_normalize (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_operand_a,
  input  logic [31:0] in_operand_b,
  input  logic [63:0] in_sig_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow
);

  localparam logic [9:0]  c_EXP_BIAS = 10'd127;
  localparam logic [7:0]  c_EXP_MAX  = 8'hFF;
  localparam logic [31:0] c_QNAN     = 32'h7FFF_FFFF;

  // ---------------------------------------------------------------- handshake
  logic w_s2_load;
  logic w_in_ready;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign in_ready   = w_in_ready;
  assign out_valid  = r_s2_valid;

  // ------------------------------------------------- stage 1: classify/exponent
  logic       w_sign_a, w_sign_b;
  logic [7:0] w_exp_a, w_exp_b;
  logic       w_frac_a_nz, w_frac_b_nz;
  logic       w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic       w_nan_res, w_inf_res, w_zero_res;
  logic       w_norm;
  logic       w_no_lead;
  logic [9:0] w_exp_sum;
  logic [22:0] w_frac;

  assign w_sign_a    = in_operand_a[31];
  assign w_sign_b    = in_operand_b[31];
  assign w_exp_a     = in_operand_a[30:23];
  assign w_exp_b     = in_operand_b[30:23];
  assign w_frac_a_nz = |in_operand_a[22:0];
  assign w_frac_b_nz = |in_operand_b[22:0];

  assign w_a_nan  = (w_exp_a == c_EXP_MAX) && w_frac_a_nz;
  assign w_b_nan  = (w_exp_b == c_EXP_MAX) && w_frac_b_nz;
  assign w_a_inf  = (w_exp_a == c_EXP_MAX) && !w_frac_a_nz;
  assign w_b_inf  = (w_exp_b == c_EXP_MAX) && !w_frac_b_nz;
  assign w_a_zero = (w_exp_a == 8'h00);
  assign w_b_zero = (w_exp_b == 8'h00);

  assign w_norm    = in_sig_product[47];
  assign w_no_lead = (in_sig_product[47:46] == 2'b00);

  assign w_nan_res  = w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero);
  assign w_inf_res  = (w_a_inf || w_b_inf) && !w_nan_res;
  // A product with no leading one is only meaningful when nothing else is special
  assign w_zero_res = !w_nan_res &&
                      ((w_a_zero || w_b_zero) || (w_no_lead && !(w_a_inf || w_b_inf)));

  assign w_exp_sum = {2'b00, w_exp_a} + {2'b00, w_exp_b} - c_EXP_BIAS + {9'd0, w_norm};
  assign w_frac    = w_norm ? in_sig_product[46:24] : in_sig_product[45:23];

`ifdef AFPM_ROUND_NEAREST_EN
  logic w_guard;
  logic w_sticky;
  assign w_guard  = w_norm ? in_sig_product[23] : in_sig_product[22];
  assign w_sticky = w_norm ? (|in_sig_product[22:0]) : (|in_sig_product[21:0]);
  logic w_unused_bits;
  assign w_unused_bits = ^in_sig_product[63:48];
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{in_sig_product[63:48], in_sig_product[22:0]};
`endif

  logic        r_s1_sign;
  logic [9:0]  r_s1_exp;
  logic [22:0] r_s1_frac;
  logic        r_s1_nan, r_s1_inf, r_s1_zero;
`ifdef AFPM_ROUND_NEAREST_EN
  logic        r_s1_guard;
  logic        r_s1_sticky;
`endif

  // ------------------------------------------------------ stage 2: round/pack
  logic [22:0] w_frac_rnd;
  logic [9:0]  w_exp_rnd;

`ifdef AFPM_ROUND_NEAREST_EN
  logic w_round_up;
  logic w_carry;
  assign w_round_up = r_s1_guard && (r_s1_sticky || r_s1_frac[0]);
  // A carry out of the fraction means the significand became 10.000..., i.e. 1.0 at exp+1
  assign {w_carry, w_frac_rnd} = {1'b0, r_s1_frac} + {23'd0, w_round_up};
  assign w_exp_rnd = r_s1_exp + {9'd0, w_carry};
`else
  assign w_frac_rnd = r_s1_frac;
  assign w_exp_rnd  = r_s1_exp;
`endif

  logic [31:0] w_result;
  logic        w_ovf;
  logic        w_unf;

  always_comb begin
    w_result = {r_s1_sign, w_exp_rnd[7:0], w_frac_rnd};
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_s1_nan) begin
      w_result = c_QNAN;
    end else if (r_s1_inf) begin
      w_result = {r_s1_sign, c_EXP_MAX, 23'd0};
    end else if (r_s1_zero) begin
      w_result = {r_s1_sign, 31'd0};
    end else if ($signed(w_exp_rnd) >= 10'sd255) begin
      w_result = {r_s1_sign, c_EXP_MAX, 23'd0};
      w_ovf    = 1'b1;
    end else if ($signed(w_exp_rnd) <= 10'sd0) begin
      w_result = {r_s1_sign, 31'd0};
      w_unf    = 1'b1;
    end
  end

  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_unf;

  assign out_result    = r_result;
  assign out_overflow  = r_ovf;
  assign out_underflow = r_unf;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= 10'd0;
      r_s1_frac   <= 23'd0;
      r_s1_nan    <= 1'b0;
      r_s1_inf    <= 1'b0;
      r_s1_zero   <= 1'b0;
`ifdef AFPM_ROUND_NEAREST_EN
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
`endif
      r_s2_valid  <= 1'b0;
      r_result    <= 32'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_sign   <= w_sign_a ^ w_sign_b;
          r_s1_exp    <= w_exp_sum;
          r_s1_frac   <= w_frac;
          r_s1_nan    <= w_nan_res;
          r_s1_inf    <= w_inf_res;
          r_s1_zero   <= w_zero_res;
`ifdef AFPM_ROUND_NEAREST_EN
          r_s1_guard  <= w_guard;
          r_s1_sticky <= w_sticky;
`endif
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result <= w_result;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_afpm_mul_normalize.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_afpm_mul_normalize
// Purpose  : Scoreboard bench for afpm_mul_normalize with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afpm_mul_normalize;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_operand_a = '0;
  logic [31:0] in_operand_b = '0;
  logic [63:0] in_sig_product = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  afpm_mul_normalize dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_operand_a   (in_operand_a),
    .in_operand_b   (in_operand_b),
    .in_sig_product (in_sig_product),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_overflow   (out_overflow),
    .out_underflow  (out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ready_pct = 100;
  int   force_low = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: value-level significand arithmetic with an integer exponent
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prod);
    exp_t r;
    int ea, eb, e, shift;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic [47:0] p, rem, half;
    logic [47:0] m;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    sgn = a[31] ^ b[31];
    r = '0;
    p = prod[47:0];
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      r.res = 32'h7FFF_FFFF;
      return r;
    end
    if (a_inf || b_inf) begin
      r.res = {sgn, 8'hFF, 23'd0};
      return r;
    end
    if (a_zero || b_zero || p < 48'h4000_0000_0000) begin
      r.res = {sgn, 31'd0};
      return r;
    end
    e = ea + eb - 127;
    if (p >= 48'h8000_0000_0000) begin
      e = e + 1;
      shift = 24;
    end else begin
      shift = 23;
    end
    m    = p >> shift;
    rem  = p - (m << shift);
    half = 48'd1 << (shift - 1);
`ifdef AFPM_ROUND_NEAREST_EN
    if (rem > half || (rem == half && (m % 2 == 1))) m = m + 1;
`else
    if (rem > half) m = m;
`endif
    if (m >= 48'd16777216) begin
      m = m / 2;
      e = e + 1;
    end
    if (e >= 255) begin
      r.res = {sgn, 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.res = {sgn, 31'd0};
      r.unf = 1'b1;
    end else begin
      r.res = {sgn, 8'(e), m[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:       v[30:23] = 8'h00;
      1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3:       v[30:23] = 8'($urandom_range(1, 25));
      4:       v[30:23] = 8'($urandom_range(225, 254));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  function automatic logic [63:0] rnd_prod();
    logic [63:0] p;
    int k;
    p = {$urandom, $urandom};
    k = $urandom_range(0, 9);
    if (k == 0)      p[47:46] = 2'b00;
    else if (k < 5)  p[47:46] = 2'b01;
    else             p[47]    = 1'b1;
    k = $urandom_range(0, 5);
    if (k == 0)      p[22:0] = 23'd0;
    else if (k == 1) p[23:0] = p[47] ? 24'h80_0000 : {p[23], 23'h40_0000};
    else if (k == 2) p[45:23] = 23'h7F_FFFF;
    return p;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p, input exp_t e);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      in_valid       = 1'b1;
      in_operand_a   = a;
      in_operand_b   = b;
      in_sig_product = p;
      #1;
      if (in_ready) begin
        sb_q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) fail_now("send_timeout");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    ready_pct = 100;
    idle(1);
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) idle(1);
    if (sb_q.size() != 0) fail_now("drain_timeout");
  endtask

  // Downstream ready generator
  initial begin
    forever begin
      @(negedge clk);
      if (force_low > 0) begin
        out_ready = 1'b0;
        force_low--;
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
    end
  end

  // Monitor: pops expected results on every output handshake and checks hold stability
  logic        prev_hold = 1'b0;
  logic [33:0] prev_out  = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_stable", {30'd0, out_result, out_overflow, out_underflow}, {30'd0, prev_out});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = sb_q.pop_front();
          check("result", {32'd0, out_result}, {32'd0, e.res});
          check("flags", {62'd0, out_overflow, out_underflow}, {62'd0, e.ovf, e.unf});
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_result, out_overflow, out_underflow};
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    exp_t e;
    bit seen;

    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_word", {30'd0, out_result, out_overflow, out_underflow}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    ready_pct = 100;
    send(32'h3FC0_0000, 32'h3FC0_0000, 64'h0000_9000_0000_0000, '{32'h4010_0000, 1'b0, 1'b0});
    send(32'h7F00_0000, 32'h4000_0000, 64'h0000_4000_0000_0000, '{32'h7F80_0000, 1'b1, 1'b0});
    send(32'h7F80_0000, 32'h0000_0000, 64'h0000_4000_0000_0000, '{32'h7FFF_FFFF, 1'b0, 1'b0});
    send(32'hFF80_0000, 32'h3F80_0000, 64'h0000_4000_0000_0000, '{32'hFF80_0000, 1'b0, 1'b0});
    send(32'h0080_0000, 32'h0080_0000, 64'h0000_4000_0000_0000, '{32'h0000_0000, 1'b0, 1'b1});
`ifdef AFPM_ROUND_NEAREST_EN
    send(32'h3F80_0000, 32'h3F80_0000, 64'h0000_4000_0040_0001, '{32'h3F80_0001, 1'b0, 1'b0});
`else
    send(32'h3F80_0000, 32'h3F80_0000, 64'h0000_4000_0040_0001, '{32'h3F80_0000, 1'b0, 1'b0});
`endif
    send(32'h3F80_0000, 32'h3F80_0000, 64'h0000_4000_0040_0000, '{32'h3F80_0000, 1'b0, 1'b0});
    drain();

    // Backpressure: 4 beats, out_ready low for 3 cycles after the first out_valid
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          a = rnd_op(); b = rnd_op(); p = rnd_prod();
          send(a, b, p, model(a, b, p));
        end
        idle(1);
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          #2;
          seen = out_valid;
        end
        if (!seen) fail_now("bp_no_output");
        force_low = 3;
        @(negedge clk);
        #3;
        check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
      end
    join
    drain();

    // Randomized stream with random backpressure
    ready_pct = 70;
    for (int i = 0; i < 300; i++) begin
      a = rnd_op(); b = rnd_op(); p = rnd_prod();
      send(a, b, p, model(a, b, p));
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    drain();

    // Asynchronous reset with both slots full
    ready_pct = 0;
    for (int i = 0; i < 2; i++) begin
      a = rnd_op(); b = rnd_op(); p = rnd_prod();
      send(a, b, p, model(a, b, p));
    end
    idle(2);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_out_word", {30'd0, out_result, out_overflow, out_underflow}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    ready_pct = 100;

    // Latency after reset: visible after the second edge following acceptance
    @(negedge clk);
    in_valid       = 1'b1;
    in_operand_a   = 32'h3FC0_0000;
    in_operand_b   = 32'h3FC0_0000;
    in_sig_product = 64'h0000_9000_0000_0000;
    #1;
    check("lat_in_ready", {63'd0, in_ready}, 64'd1);
    e = '{32'h4010_0000, 1'b0, 1'b0};
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_cycle1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    #1;
    check("lat_cycle2", {63'd0, out_valid}, 64'd1);
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/afpm_mul_normalize.md
# afpm_mul_normalize

Two-stage pipelined normalize/round/pack stage placed directly after the approximate significand multiplier in the floating-point multiply path. It takes the 64-bit significand product, with its hidden bit at bit 47 or 46, plus the two original float32 operands. It produces the packed IEEE-754 single-precision result, and handles special operands, exponent overflow/underflow and rounding. A valid/ready handshake with full backpressure lets the block sit in a stallable lane.

## Interface
Parameters: none; float32 widths are fixed, 8-bit exponent and 23-bit fraction.

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_operand_a  in  32  float32 multiplier operand
- in_operand_b  in  32  float32 multiplicand operand
- in_sig_product  in  64  significand product; bits 63:48 ignored
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- out_result  out  32  packed float32 product
- out_overflow  out  1  result saturated to infinity by exponent overflow
- out_underflow  out  1  result flushed to zero by exponent underflow

## Operation
- Handshake: a beat transfers when valid && ready on a clock edge. Two register slots, S1 and S2.
- S2 loads when it is empty or its beat is being taken (out_ready). S1 advances under the same condition.
- in_ready = !S1.valid || S1 advancing. in_ready never depends combinationally on in_valid.
- Stage 1 (classify and exponent), registered into S1:
  - Classify each operand: NaN (exp=FF, frac≠0), Inf (exp=FF, frac=0), Zero (exp=0).
  - nan_res = any NaN, or Zero×Inf. inf_res = any Inf and not nan_res. zero_res = any Zero and not nan_res.
  - norm = in_sig_product[47].
  - exp_sum is 10-bit signed: {2'b0,exp_a} + {2'b0,exp_b} − 127 + norm.
  - sign = sign_a ^ sign_b.
  - frac = norm ? prod[46:24] : prod[45:23]. guard = norm ? prod[23] : prod[22]. sticky = OR of all bits below guard.
  - If prod[47:46]==2'b00 and no special case applies, set zero_res.
- Stage 2 (round and pack), registered into S2:
  - Rounding is per Configuration. A round carry out of frac sets frac=0 and increments exp_sum.
  - Priority, first match wins:
    - nan_res → 32'h7FFFFFFF.
    - inf_res → {sign, 8'hFF, 23'h0}.
    - zero_res → {sign, 31'h0}.
    - exp ≥ 255 after rounding → {sign, 8'hFF, 23'h0} and overflow=1.
    - exp ≤ 0 → {sign, 31'h0} and underflow=1. No subnormal outputs are produced.
    - Otherwise → {sign, exp[7:0], frac}.
- out_overflow and out_underflow are valid only with out_valid, and are 0 for special results.

## Timing
- Latency: 2 cycles from input accept to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- Reset (reset_n low, asynchronous): S1.valid=0, S2.valid=0, out_valid=0, out_result=0, out_overflow=0, out_underflow=0. in_ready reads 1 while reset_n is low.
- Reset mid-operation discards all in-flight beats immediately, without waiting for a clock edge.
- Backpressure: while out_valid && !out_ready, out_result and both flags are held stable. With both slots full, in_ready=0.
- Full pipe with out_ready=1 and in_valid=1: S2 outputs, S1 moves to S2 and the new beat enters S1 on the same edge. No bubble.
- Data registers load only on advance. Holding data when valid=0 is don't-care, but out_result must not be X after reset.

## Configuration
- AFPM_ROUND_NEAREST_EN defined: round to nearest, ties to even. Increment frac when guard && (sticky || frac[0]).
- Not defined: truncate. guard and sticky are ignored, and no round-carry logic or sticky OR-tree is instantiated.
- The approximate multiplier path normally builds without the macro, because its low product bits are zero.

## Test plan
- Normal case: a=b=32'h3FC00000, prod=64'h0000_9000_0000_0000 → out_result=32'h40100000 after 2 cycles, flags 0.
- Overflow: a=32'h7F000000, b=32'h40000000, prod=64'h0000_4000_0000_0000 → 32'h7F800000, out_overflow=1.
- Special cases:
  - a=32'h7F800000, b=32'h00000000 → 32'h7FFFFFFF.
  - a=32'hFF800000, b=32'h3F800000 → 32'hFF800000.
- Rounding, a=b=32'h3F800000:
  - prod=64'h0000_4000_0040_0001 → 32'h3F800001 with the macro, 32'h3F800000 without.
  - prod=64'h0000_4000_0040_0000 → 32'h3F800000 with the macro (tie to even).
- Backpressure: stream 4 beats, hold out_ready=0 for 3 cycles after the first out_valid.
  - Required: in_ready drops when both slots are full, out_result is stable while held, and all 4 results appear in order with no loss or duplication.
- Reset: pull reset_n low between clock edges with both slots valid → out_valid=0 immediately. After release, the first new beat appears 2 cycles after acceptance.
